uart_tx_sched: RTL and testbench

Transmit scheduler that shares the single `uart_tx` byte transmitter between two requesters: the CPU debug byte stream and a periodic 4-byte status beacon. It sits between `riscv_multi`'s debug outputs and `uart_tx` in `top`. It buffers CPU bytes in a small FIFO, arbitrates round-robin at frame granularity, and drives the transmitter's data-valid/byte inputs one byte at a time, pacing on `tx_Done`.

---
 rtl/uart_tx_sched.sv | 254 +++++++++++++++++++++++++
 tb/tb_uart_tx_sched.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: shares one byte-wide UART transmitter between the CPU debug
// byte stream (buffered in a small FIFO) and a periodic 4-byte status beacon.
// Arbitration is round-robin at frame granularity; one byte is issued per
// transmitter tx_Done handshake.
`timescale 1ns/1ps

module uart_tx_sched #(
  parameter int FIFO_DEPTH    = 4,
  parameter int BEACON_PERIOD = 12000000,
  parameter int BEACON_EN     = 1
) (
  input  logic                          CLK12MHZ,
  input  logic                          resetn,
  input  logic [7:0]                    cpu_tx_byte,
  input  logic                          cpu_tx_valid,
  output logic                          cpu_tx_ready,
  input  logic [7:0]                    status_word,
  output logic [7:0]                    tx_byte,
  output logic                          tx_DataValid,
  input  logic                          tx_Active,
  input  logic                          tx_Done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          beacon_overrun
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(BEACON_PERIOD);

  localparam logic [LW-1:0] LEVEL_FULL = LW'(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_MAX    = CW'(BEACON_PERIOD - 1);
  localparam logic [7:0]    SYNC_BYTE  = 8'hA5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT
  } state_t;

  typedef enum logic {
    SRC_CPU,
    SRC_BCN
  } src_t;

  // ---------------------------------------------------------------------------
  // CPU byte FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] count;
  logic          push;
  logic          pop;

  assign cpu_tx_ready = (count != LEVEL_FULL);
  assign fifo_level   = count;
  assign push         = cpu_tx_valid && cpu_tx_ready;

  // Storage array: written on push only.
  // NOTE: the byte array has no reset; its contents are never read before a
  // push writes them, and leaving it unreset lets it map onto plain RAM/LUTs.
  always_ff @(posedge CLK12MHZ) begin
    if (push) begin
      mem[wr_ptr] <= cpu_tx_byte;
    end
  end

  // Pointers and occupancy; power-of-two depth lets the pointers wrap naturally.
  // NOTE: every sequential block uses non-blocking assignments so all
  // registers update from the same pre-edge values, with no ordering races.
  always_ff @(posedge CLK12MHZ or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Beacon tick generator and pending-beacon bookkeeping
  // ---------------------------------------------------------------------------
  logic [CW-1:0] bcn_cnt;
  logic          tick;
  logic          pending;
  logic [7:0]    seq;
  logic [7:0]    stat_q;
  logic          bcn_grant;
  logic          cpu_grant;

  assign tick = (BEACON_EN != 0) && (bcn_cnt == CNT_MAX);

  // Free-running period counter; held at zero when the beacon is disabled.
  always_ff @(posedge CLK12MHZ or negedge resetn) begin
    if (!resetn) begin
      bcn_cnt <= '0;
    end else if ((BEACON_EN == 0) || (bcn_cnt == CNT_MAX)) begin
      bcn_cnt <= '0;
    end else begin
      bcn_cnt <= bcn_cnt + CW'(1);
    end
  end

  // A tick arms a new beacon unless one is still waiting to start, in which
  // case the tick is dropped and the sticky overrun flag records it.
  always_ff @(posedge CLK12MHZ or negedge resetn) begin
    if (!resetn) begin
      pending        <= 1'b0;
      seq            <= 8'h00;
      stat_q         <= 8'h00;
      beacon_overrun <= 1'b0;
    end else begin
      if (bcn_grant) begin
        pending <= 1'b0;
      end
      if (tick) begin
        if (pending) begin
          beacon_overrun <= 1'b1;
        end else begin
          pending <= 1'b1;
          stat_q  <= status_word;
          seq     <= seq + 8'd1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Issue FSM
  // ---------------------------------------------------------------------------
  state_t     state_q;
  state_t     state_d;
  src_t       src_q;
  src_t       last_q;
  logic [1:0] idx_q;
  logic [7:0] frm_seq;
  logic [7:0] frm_stat;
  logic [7:0] frame_byte;
  logic [7:0] byte_d;
  logic       dv_d;
  logic       arb_open;
  logic       cpu_cand;
  logic       frame_more;

  // Round-robin decision, only taken while idle with the transmitter free.
  assign cpu_cand   = (count != '0);
  assign arb_open   = (state_q == S_IDLE) && !tx_Active;
  assign cpu_grant  = arb_open && cpu_cand && (!pending || (last_q == SRC_BCN));
  assign bcn_grant  = arb_open && pending  && (!cpu_cand || (last_q == SRC_CPU));
  assign frame_more = (src_q == SRC_BCN) && (idx_q != 2'd3);

  // State register.
  always_ff @(posedge CLK12MHZ or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a beacon frame stays atomic by looping WAIT->LOAD.
  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (cpu_grant || bcn_grant) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (tx_Done) begin
          state_d = frame_more ? S_LOAD : S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Frame byte selected by the index; values were latched at grant so a
  // beacon tick during the frame cannot corrupt it.
  always_comb begin
    case (idx_q)
      2'd0:    frame_byte = SYNC_BYTE;
      2'd1:    frame_byte = frm_seq;
      2'd2:    frame_byte = frm_stat;
      default: frame_byte = SYNC_BYTE ^ frm_seq ^ frm_stat;
    endcase
  end

  // Output decode: LOAD produces the byte, the strobe and (for CPU) the pop.
  always_comb begin
    dv_d   = 1'b0;
    pop    = 1'b0;
    byte_d = tx_byte;
    if (state_q == S_LOAD) begin
      dv_d = 1'b1;
      if (src_q == SRC_CPU) begin
        pop    = 1'b1;
        byte_d = mem[rd_ptr];
      end else begin
        byte_d = frame_byte;
      end
    end
  end

  // Registered transmitter interface plus grant/source/index bookkeeping.
  always_ff @(posedge CLK12MHZ or negedge resetn) begin
    if (!resetn) begin
      tx_byte      <= 8'h00;
      tx_DataValid <= 1'b0;
      src_q        <= SRC_CPU;
      last_q       <= SRC_BCN;
      idx_q        <= 2'd0;
      frm_seq      <= 8'h00;
      frm_stat     <= 8'h00;
    end else begin
      tx_byte      <= byte_d;
      tx_DataValid <= dv_d;
      if (cpu_grant) begin
        src_q  <= SRC_CPU;
        last_q <= SRC_CPU;
      end
      if (bcn_grant) begin
        src_q    <= SRC_BCN;
        last_q   <= SRC_BCN;
        idx_q    <= 2'd0;
        frm_seq  <= seq;
        frm_stat <= stat_q;
      end
      if ((state_q == S_WAIT) && tx_Done && frame_more) begin
        idx_q <= idx_q + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: a small uart_tx behavioural model
// answers each strobe with a busy period and a tx_Done pulse; expected bytes
// are queued as stimulus is applied and compared as the strobes appear.
`timescale 1ns/1ps

module tb_uart_tx_sched;

  localparam int DEPTH  = 4;
  localparam int PERIOD = 96;
  localparam int LW     = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          resetn = 1'b1;
  logic [7:0]    cpu_tx_byte = 8'h00;
  logic          cpu_tx_valid = 1'b0;
  logic          cpu_tx_ready;
  logic [7:0]    status_word = 8'h00;
  logic [7:0]    tx_byte;
  logic          tx_DataValid;
  logic          tx_Active;
  logic          tx_Done = 1'b0;
  logic [LW-1:0] fifo_level;
  logic          beacon_overrun;

  logic          model_busy = 1'b0;
  logic [2:0]    model_cnt = 3'd0;
  logic          hold_active = 1'b0;
  logic          prev_dv = 1'b0;
  logic [7:0]    mon_exp;
  logic [7:0]    sb [$];

  int checks = 0;
  int errors = 0;

  assign tx_Active = model_busy | hold_active;

  always #5 clk = ~clk;

  uart_tx_sched #(
    .FIFO_DEPTH   (DEPTH),
    .BEACON_PERIOD(PERIOD),
    .BEACON_EN    (1)
  ) dut (
    .CLK12MHZ      (clk),
    .resetn        (resetn),
    .cpu_tx_byte   (cpu_tx_byte),
    .cpu_tx_valid  (cpu_tx_valid),
    .cpu_tx_ready  (cpu_tx_ready),
    .status_word   (status_word),
    .tx_byte       (tx_byte),
    .tx_DataValid  (tx_DataValid),
    .tx_Active     (tx_Active),
    .tx_Done       (tx_Done),
    .fifo_level    (fifo_level),
    .beacon_overrun(beacon_overrun)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // uart_tx model: busy for a few cycles after each strobe, then a Done pulse.
  always @(posedge clk) begin
    tx_Done <= 1'b0;
    if (tx_DataValid) begin
      model_busy <= 1'b1;
      model_cnt  <= 3'd3;
    end else if (model_busy) begin
      if (model_cnt == 3'd0) begin
        model_busy <= 1'b0;
        tx_Done    <= 1'b1;
      end else begin
        model_cnt <= model_cnt - 3'd1;
      end
    end
  end

  // Scoreboard: every strobe must match the next expected byte.
  always @(negedge clk) begin
    if (tx_DataValid) begin
      check("dv_back_to_back", prev_dv, 1'b0);
      check("dv_while_active", tx_Active, 1'b0);
      if (sb.size() == 0) begin
        check("dv_unexpected", 1'b1, 1'b0);
      end else begin
        mon_exp = sb.pop_front();
        check("tx_byte", tx_byte, mon_exp);
      end
    end
    prev_dv = tx_DataValid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    resetn       = 1'b0;
    hold_active  = 1'b0;
    cpu_tx_valid = 1'b0;
    sb.delete();
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  task automatic push(input logic [7:0] b, input bit enq, output bit acc);
    cpu_tx_byte  = b;
    cpu_tx_valid = 1'b1;
    acc = cpu_tx_ready;
    if (acc && enq) sb.push_back(b);
    @(posedge clk);
    #1 cpu_tx_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((sb.size() != 0 || model_busy || tx_Done) && n < budget) begin
      @(posedge clk);
      n++;
    end
    check("drain_in_time", (n < budget), 1'b1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input logic [7:0] s, input logic [7:0] st);
    sb.push_back(8'hA5);
    sb.push_back(s);
    sb.push_back(st);
    sb.push_back(8'hA5 ^ s ^ st);
  endtask

  initial begin
    bit acc;
    int n;
    int dv_cnt;

    // Reset values while reset is asserted.
    #1 resetn = 1'b0;
    #2;
    check("rst_dv", tx_DataValid, 1'b0);
    check("rst_byte", tx_byte, 8'h00);
    check("rst_level", fifo_level, 0);
    check("rst_ready", cpu_tx_ready, 1'b1);
    check("rst_overrun", beacon_overrun, 1'b0);

    // Single CPU byte with exact latency.
    do_reset();
    push(8'h41, 1'b1, acc);
    check("single_acc", acc, 1'b1);
    @(negedge clk) check("lat_n0", tx_DataValid, 1'b0);
    @(negedge clk) check("lat_n1", tx_DataValid, 1'b0);
    @(negedge clk) check("lat_n2", tx_DataValid, 1'b1);
    drain(100);
    check("single_level", fifo_level, 0);

    // FIFO fill while the transmitter is busy; fifth push refused.
    do_reset();
    hold_active = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push(8'h20 + 8'(i), 1'b1, acc);
      check("fill_acc", acc, 1'b1);
    end
    check("full_ready", cpu_tx_ready, 1'b0);
    check("full_level", fifo_level, 4);
    push(8'h24, 1'b1, acc);
    check("fifth_refused", acc, 1'b0);
    hold_active = 1'b0;
    drain(300);
    check("fill_level_end", fifo_level, 0);
    check("fill_ready_end", cpu_tx_ready, 1'b1);

    // Beacon frame with no CPU traffic.
    do_reset();
    status_word = 8'h3C;
    push_frame(8'h01, 8'h3C);
    drain(400);
    check("beacon_no_overrun", beacon_overrun, 1'b0);

    // Contention: CPU wins the first contest, frame is atomic.
    do_reset();
    hold_active = 1'b1;
    status_word = 8'h66;
    push(8'h10, 1'b0, acc);
    push(8'h11, 1'b0, acc);
    repeat (PERIOD + 4) @(posedge clk);
    #1;
    check("cont_level", fifo_level, 2);
    sb.push_back(8'h10);
    push_frame(8'h01, 8'h66);
    sb.push_back(8'h11);
    hold_active = 1'b0;
    drain(400);

    // Overrun: second tick while first beacon still waits.
    do_reset();
    hold_active = 1'b1;
    status_word = 8'h5A;
    repeat (150) @(posedge clk);
    #1 check("ovr_before", beacon_overrun, 1'b0);
    status_word = 8'h77;
    repeat (50) @(posedge clk);
    #1 check("ovr_after", beacon_overrun, 1'b1);
    push_frame(8'h01, 8'h5A);
    hold_active = 1'b0;
    drain(400);
    check("ovr_sticky", beacon_overrun, 1'b1);

    // Reset in the middle of beacon byte 2.
    do_reset();
    status_word = 8'h3C;
    sb.push_back(8'hA5);
    sb.push_back(8'h01);
    sb.push_back(8'h3C);
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("midframe_reached", (n < 300), 1'b1);
    @(posedge clk);
    #2 resetn = 1'b0;
    hold_active = 1'b1;
    #1;
    check("mid_rst_dv", tx_DataValid, 1'b0);
    check("mid_rst_byte", tx_byte, 8'h00);
    check("mid_rst_level", fifo_level, 0);
    check("mid_rst_ready", cpu_tx_ready, 1'b1);
    check("mid_rst_overrun", beacon_overrun, 1'b0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    push(8'h55, 1'b1, acc);
    dv_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (tx_DataValid) dv_cnt++;
    end
    check("no_dv_while_active", dv_cnt, 0);
    check("held_level", fifo_level, 1);
    @(posedge clk);
    #1 hold_active = 1'b0;
    drain(200);
    check("post_rst_level", fifo_level, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
